// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for the single-cycle ARM-subset CPU.
// Sequences the core through program loading, free run, single-step and
// halt. Owns the instruction RAM write port while loading, holds the core
// in reset until a program is started, and gates all architectural state
// updates through cpu_en.
//
// Loader handshake: a word transfers on every rising edge where
// ld_valid && ld_ready. ld_ready depends only on the registered state
// (high exactly in LOAD), and the loader must hold ld_data/ld_last stable
// while ld_valid is high and ld_ready is low.
module cpu_run_ctrl #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] HALT_WORD  = 32'hEAFF_FFFE,
  parameter int          CYC_W      = 32,
  localparam int         AW         = $clog2(IMEM_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             step_mode,
  input  logic             step,
  input  logic             halt_req,
  input  logic [31:0]      instr,
  input  logic             ld_valid,
  input  logic [31:0]      ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             imem_we,
  output logic [AW-1:0]    imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             cpu_rst,
  output logic             cpu_en,
  output logic [CYC_W-1:0] cycle_count,
  output logic             busy,
  output logic             halted,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(IMEM_DEPTH - 1);

  state_t          state_q;
  logic [AW-1:0]   ptr_q;
  logic            is_halt_word;
  logic            launch;

  assign is_halt_word = (instr == HALT_WORD);

  // A launch from IDLE: start wins only when neither clear nor a loader word is pending.
  assign launch = (state_q == S_IDLE) && !clear && !ld_valid && start;

  // Decode status outputs from the registered state; write port and enable are same-cycle.
  always_comb begin
    state      = state_q;
    ld_ready   = (state_q == S_LOAD);
    cpu_rst    = (state_q == S_IDLE) || (state_q == S_LOAD);
    busy       = (state_q == S_RUN) || (state_q == S_STEP);
    halted     = (state_q == S_HALT);
    imem_we    = (state_q == S_LOAD) && ld_valid;
    imem_addr  = (state_q == S_LOAD) ? ptr_q : '0;
    imem_wdata = ld_data;
    cpu_en     = 1'b0;
    case (state_q)
      S_RUN:   cpu_en = !is_halt_word;
      S_STEP:  cpu_en = step && !is_halt_word;
      default: cpu_en = 1'b0;
    endcase
  end

  // Control FSM and load pointer; clear has priority, then halt detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clear) begin
            state_q <= S_IDLE;
          end else if (ld_valid) begin
            state_q <= S_LOAD;
            ptr_q   <= '0;
          end else if (start) begin
            state_q <= step_mode ? S_STEP : S_RUN;
          end
        end
        S_LOAD: begin
          if (clear) begin
            state_q <= S_IDLE;
          end else if (ld_valid) begin
            // The pointer stops at the last word instead of wrapping.
            if (ld_last || (ptr_q == LAST_ADDR)) begin
              state_q <= S_IDLE;
            end else begin
              ptr_q <= ptr_q + AW'(1);
            end
          end
        end
        S_RUN: begin
          if (clear) begin
            state_q <= S_IDLE;
          end else if (is_halt_word || halt_req) begin
            state_q <= S_HALT;
          end else if (step_mode) begin
            state_q <= S_STEP;
          end
        end
        S_STEP: begin
          if (clear) begin
            state_q <= S_IDLE;
          end else if (is_halt_word) begin
            state_q <= S_HALT;
          end else if (!step_mode) begin
            state_q <= S_RUN;
          end
        end
        S_HALT: begin
          // Resume keeps the core out of reset; a core parked on the halt word re-halts.
          if (clear) begin
            state_q <= S_IDLE;
          end else if (start) begin
            state_q <= step_mode ? S_STEP : S_RUN;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Executed-instruction counter: restarts on launch, saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
    end else if (launch) begin
      cycle_count <= '0;
    end else if (cpu_en && (cycle_count != '1)) begin
      cycle_count <= cycle_count + CYC_W'(1);
    end
  end

endmodule
